// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: synchronizes and de-glitches the PS/2 lines, frames
// 11-bit packets, strips E0/F0 prefixes and emits one event per key action.
module ps2_scancode_rx #(
    parameter int CLK_HZ      = 100_000_000,
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 200_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] code,
    output logic       is_break,
    output logic       is_ext,
    output logic       code_valid,
    output logic       frame_err,
    output logic [7:0] err_cnt
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    if (FILTER_LEN < 2 || FILTER_LEN > 255 || CLK_HZ <= 0) begin : g_bad_param
        $error("ps2_scancode_rx: parameter out of range");
    end

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    logic          clk_s1_q, clk_s2_q;
    logic          dat_s1_q, dat_s2_q;
    logic          filt_q, filt_d;
    logic [7:0]    fcnt_q, fcnt_d;
    logic          fall;

    state_t        state_q, state_d;
    logic [2:0]    bcnt_q, bcnt_d;
    logic [7:0]    sh_q, sh_d;
    logic          par_q, par_d;
    logic [TW-1:0] to_q, to_d;
    logic          timeout;
    logic          good, bad;

    logic          ext_pend_q, ext_pend_d;
    logic          brk_pend_q, brk_pend_d;
    logic [7:0]    code_q, code_d;
    logic          brk_q, brk_d;
    logic          ext_q, ext_d;
    logic          cv_q, cv_d;
    logic          fe_q, fe_d;
    logic [7:0]    err_q, err_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
            filt_q   <= 1'b1;
            fcnt_q   <= '0;
        end else begin
            clk_s1_q <= ps2_clk;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= ps2_data;
            dat_s2_q <= dat_s1_q;
            filt_q   <= filt_d;
            fcnt_q   <= fcnt_d;
        end
    end

    // Any cycle matching the current filtered level restarts the run count
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        fall   = 1'b0;
        if (clk_s2_q != filt_q) begin
            if (fcnt_q == 8'(FILTER_LEN - 1)) begin
                filt_d = clk_s2_q;
                fall   = filt_q;
            end else begin
                fcnt_d = fcnt_q + 8'd1;
            end
        end
    end

    assign timeout = (state_q != IDLE) && !fall && (to_q == TW'(TIMEOUT_CYC));

    always_comb begin
        state_d    = state_q;
        bcnt_d     = bcnt_q;
        sh_d       = sh_q;
        par_d      = par_q;
        to_d       = '0;
        good       = 1'b0;
        bad        = 1'b0;
        ext_pend_d = ext_pend_q;
        brk_pend_d = brk_pend_q;
        code_d     = code_q;
        brk_d      = brk_q;
        ext_d      = ext_q;
        cv_d       = 1'b0;
        fe_d       = 1'b0;
        err_d      = err_q;

        if (state_q != IDLE && !fall) begin
            to_d = to_q + TW'(1);
        end

        if (fall) begin
            unique case (state_q)
                IDLE: begin
                    if (!dat_s2_q) begin
                        state_d = DATA;
                        bcnt_d  = '0;
                    end
                end
                DATA: begin
                    sh_d   = {dat_s2_q, sh_q[7:1]};
                    bcnt_d = bcnt_q + 3'd1;
                    if (bcnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    par_d   = dat_s2_q;
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if ((^{sh_q, par_q}) && dat_s2_q) begin
                        good = 1'b1;
                    end else begin
                        bad = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (timeout) begin
            state_d = IDLE;
            to_d    = '0;
            bad     = 1'b1;
        end

        if (bad) begin
            fe_d       = 1'b1;
            err_d      = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
            ext_pend_d = 1'b0;
            brk_pend_d = 1'b0;
        end else if (good) begin
            if (sh_q == 8'hE0) begin
                ext_pend_d = 1'b1;
            end else if (sh_q == 8'hF0) begin
                brk_pend_d = 1'b1;
            end else begin
                code_d     = sh_q;
                brk_d      = brk_pend_q;
                ext_d      = ext_pend_q;
                cv_d       = 1'b1;
                ext_pend_d = 1'b0;
                brk_pend_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            bcnt_q     <= '0;
            sh_q       <= '0;
            par_q      <= 1'b0;
            to_q       <= '0;
            ext_pend_q <= 1'b0;
            brk_pend_q <= 1'b0;
            code_q     <= '0;
            brk_q      <= 1'b0;
            ext_q      <= 1'b0;
            cv_q       <= 1'b0;
            fe_q       <= 1'b0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            bcnt_q     <= bcnt_d;
            sh_q       <= sh_d;
            par_q      <= par_d;
            to_q       <= to_d;
            ext_pend_q <= ext_pend_d;
            brk_pend_q <= brk_pend_d;
            code_q     <= code_d;
            brk_q      <= brk_d;
            ext_q      <= ext_d;
            cv_q       <= cv_d;
            fe_q       <= fe_d;
            err_q      <= err_d;
        end
    end

    assign code       = code_q;
    assign is_break   = brk_q;
    assign is_ext     = ext_q;
    assign code_valid = cv_q;
    assign frame_err  = fe_q;
    assign err_cnt    = err_q;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Scoreboard bench for ps2_scancode_rx: directed PS/2 frames push expected
// events into a queue that a monitor drains on each output pulse.
module tb_ps2_scancode_rx;

    localparam int FL = 4;
    localparam int TO = 200;
    localparam int H  = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] code;
    logic       is_break;
    logic       is_ext;
    logic       code_valid;
    logic       frame_err;
    logic [7:0] err_cnt;

    ps2_scancode_rx #(
        .CLK_HZ(100_000_000),
        .FILTER_LEN(FL),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .ps2_clk(ps2_clk),
        .ps2_data(ps2_data),
        .code(code),
        .is_break(is_break),
        .is_ext(is_ext),
        .code_valid(code_valid),
        .frame_err(frame_err),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_err;
        logic [7:0] code;
        logic       brk;
        logic       ext;
        logic [7:0] ecnt;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   passes = 0;
    bit   m_ext = 0;
    bit   m_brk = 0;
    int   m_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic push_exp(input logic [7:0] b, input bit good);
        exp_t e;
        if (!good) begin
            m_err = (m_err < 255) ? m_err + 1 : 255;
            e = '{1'b1, 8'h00, 1'b0, 1'b0, 8'(m_err)};
            q.push_back(e);
            m_ext = 0;
            m_brk = 0;
        end else if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else begin
            e = '{1'b0, b, m_brk, m_ext, 8'(m_err)};
            q.push_back(e);
            m_ext = 0;
            m_brk = 0;
        end
    endtask

    task automatic send_bit(input logic v);
        ps2_data = v;
        repeat (H) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (H) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic frame(input logic [7:0] b, input bit pflip, input bit stop);
        push_exp(b, !pflip && stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(~(^b) ^ pflip);
        send_bit(stop);
    endtask

    always @(negedge clk) begin
        if (!reset && (code_valid || frame_err)) begin
            exp_t e;
            if (code_valid && frame_err) begin
                checks++;
                $display("FAIL both_pulses: code_valid=1 frame_err=1, expected one");
            end
            if (q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_pulse: cv=%0b fe=%0b code=%0h, expected none",
                         code_valid, frame_err, code);
            end else begin
                e = q.pop_front();
                chk("pulse_kind_err", {31'd0, frame_err}, {31'd0, e.is_err});
                chk("pulse_kind_cv", {31'd0, code_valid}, {31'd0, !e.is_err});
                chk("err_cnt", {24'd0, err_cnt}, {24'd0, e.ecnt});
                if (!e.is_err) begin
                    chk("code", {24'd0, code}, {24'd0, e.code});
                    chk("is_break", {31'd0, is_break}, {31'd0, e.brk});
                    chk("is_ext", {31'd0, is_ext}, {31'd0, e.ext});
                end
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_code", {24'd0, code}, 32'd0);
        chk("rst_cv", {31'd0, code_valid}, 32'd0);
        chk("rst_fe", {31'd0, frame_err}, 32'd0);
        chk("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
        chk("rst_flags", {30'd0, is_break, is_ext}, 32'd0);
        reset = 1'b0;
        repeat (10) @(negedge clk);

        frame(8'h16, 0, 1);
        frame(8'hF0, 0, 1);
        frame(8'h1C, 0, 1);
        frame(8'h1C, 0, 1);
        frame(8'hE0, 0, 1);
        frame(8'hF0, 0, 1);
        frame(8'h75, 0, 1);
        frame(8'h45, 1, 1);
        repeat (4) @(negedge clk);
        chk("err_cnt_after_parity", {24'd0, err_cnt}, 32'd1);
        frame(8'hE0, 0, 1);
        frame(8'h33, 0, 0);
        frame(8'h1E, 0, 1);
        repeat (4) @(negedge clk);
        chk("err_cnt_after_stop", {24'd0, err_cnt}, 32'd2);
        chk("ext_cleared_by_err", {31'd0, is_ext}, 32'd0);

        push_exp(8'h00, 0);
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        repeat (TO + 100) @(negedge clk);
        chk("err_cnt_after_timeout", {24'd0, err_cnt}, 32'd3);
        frame(8'h26, 0, 1);

        ps2_data = 1'b0;
        ps2_clk  = 1'b0;
        repeat (FL - 1) @(negedge clk);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (20) @(negedge clk);
        frame(8'h16, 0, 1);

        for (int i = 0; i < 300; i++) frame(8'h00, 0, 0);
        repeat (4) @(negedge clk);
        chk("err_cnt_saturated", {24'd0, err_cnt}, 32'd255);

        frame(8'hE0, 0, 1);
        frame(8'h29, 0, 1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst_code", {24'd0, code}, 32'd0);
        chk("midrst_err_cnt", {24'd0, err_cnt}, 32'd0);
        chk("midrst_flags", {28'd0, is_break, is_ext, code_valid, frame_err}, 32'd0);
        m_ext = 0;
        m_brk = 0;
        m_err = 0;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        frame(8'h5A, 0, 1);
        repeat (40) @(negedge clk);

        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            $display("FAIL missing_pulse: got no pulse, expected err=%0b code=%0h", e.is_err, e.code);
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
